// File: rtl/fft_float_pkg.sv
// rtl/fft_float_pkg.sv - operand/result widths shared by the FFT multiplier scheduler
package fft_float_pkg;

    localparam int MANT_W     = 10;
    localparam int EXP_W      = 5;
    localparam int RES_MANT_W = 15;

    // Requester id width; at least one bit even for degenerate counts.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fft_mult_scheduler_if.sv
// rtl/fft_mult_scheduler_if.sv - requester and multiplier-side bus of the shared multiplier scheduler
interface fft_mult_scheduler_if #(
    parameter int NREQ = 4
);
    import fft_float_pkg::*;

    localparam int ID_W = id_width(NREQ);

    logic [NREQ-1:0]        iReqValid;
    logic [NREQ-1:0]        oReqReady;
    logic [NREQ*MANT_W-1:0] iReqMant1;
    logic [NREQ*EXP_W-1:0]  iReqExp1;
    logic [NREQ*MANT_W-1:0] iReqMant2;
    logic [NREQ*EXP_W-1:0]  iReqExp2;

    logic                   oMulStart;
    logic [MANT_W-1:0]      oMulMant1;
    logic [EXP_W-1:0]       oMulExp1;
    logic [MANT_W-1:0]      oMulMant2;
    logic [EXP_W-1:0]       oMulExp2;
    logic [RES_MANT_W-1:0]  iMulMantR;
    logic [EXP_W-1:0]       iMulExpR;

    logic                   oRspValid;
    logic [ID_W-1:0]        oRspId;
    logic [RES_MANT_W-1:0]  oRspMant;
    logic [EXP_W-1:0]       oRspExp;

    modport slave (
        input  iReqValid, iReqMant1, iReqExp1, iReqMant2, iReqExp2,
        input  iMulMantR, iMulExpR,
        output oReqReady,
        output oMulStart, oMulMant1, oMulExp1, oMulMant2, oMulExp2,
        output oRspValid, oRspId, oRspMant, oRspExp
    );

    modport master (
        output iReqValid, iReqMant1, iReqExp1, iReqMant2, iReqExp2,
        output iMulMantR, iMulExpR,
        input  oReqReady,
        input  oMulStart, oMulMant1, oMulExp1, oMulMant2, oMulExp2,
        input  oRspValid, oRspId, oRspMant, oRspExp
    );

endinterface

// File: rtl/fft_rr_arbiter.sv
// rtl/fft_rr_arbiter.sv - combinational round-robin grant starting at a supplied pointer
module fft_rr_arbiter
    import fft_float_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            grant_any
);

    int              idx;
    logic [ID_W-1:0] sel;

    // Scan NREQ positions from ptr, wrapping; first requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sel = ID_W'(idx);
            if (!grant_any && req[sel]) begin
                grant_any  = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/fft_mult_scheduler.sv
// rtl/fft_mult_scheduler.sv - shares one multiplier among NREQ requesters; FFT_MULT_OPCNT_EN adds oOpCount
module fft_mult_scheduler
    import fft_float_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MUL_LAT  = 2,
    parameter int MUL_PIPE = 0
) (
    input  logic                 clkExt,
    input  logic                 rstN,
    fft_mult_scheduler_if.slave  bus
`ifdef FFT_MULT_OPCNT_EN
    ,
    output logic [15:0]          oOpCount
`endif
);

    localparam int ID_W = id_width(NREQ);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   gnt_idx;
    logic [NREQ-1:0]   gnt;
    logic              gnt_any;
    logic              busy;
    logic              can_issue;
    logic              accept;
    logic [ID_W-1:0]   issue_id;
    logic [ID_W-1:0]   next_ptr;

    logic [MANT_W-1:0] sel_mant1;
    logic [EXP_W-1:0]  sel_exp1;
    logic [MANT_W-1:0] sel_mant2;
    logic [EXP_W-1:0]  sel_exp2;

    logic [MUL_LAT-1:0] tag_v;
    logic [ID_W-1:0]    tag_id [MUL_LAT];

    fft_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (bus.iReqValid),
        .ptr       (rr_ptr),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .grant_any (gnt_any)
    );

    assign can_issue     = (MUL_PIPE != 0) ? 1'b1 : !busy;
    assign bus.oReqReady = can_issue ? gnt : '0;
    assign accept        = can_issue & gnt_any;
    assign next_ptr      = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        sel_mant1 = bus.iReqMant1[int'(gnt_idx)*MANT_W +: MANT_W];
        sel_exp1  = bus.iReqExp1[int'(gnt_idx)*EXP_W +: EXP_W];
        sel_mant2 = bus.iReqMant2[int'(gnt_idx)*MANT_W +: MANT_W];
        sel_exp2  = bus.iReqExp2[int'(gnt_idx)*EXP_W +: EXP_W];
    end

    // The tag pipe is fed from the issue strobe, so its tap lines up with the
    // cycle the multiplier result is valid; the response registers one cycle later.
    always_ff @(posedge clkExt or negedge rstN) begin
        if (!rstN) begin
            rr_ptr        <= '0;
            busy          <= 1'b0;
            issue_id      <= '0;
            bus.oMulStart <= 1'b0;
            bus.oMulMant1 <= '0;
            bus.oMulExp1  <= '0;
            bus.oMulMant2 <= '0;
            bus.oMulExp2  <= '0;
            tag_v         <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_id[i] <= '0;
            end
            bus.oRspValid <= 1'b0;
            bus.oRspId    <= '0;
            bus.oRspMant  <= '0;
            bus.oRspExp   <= '0;
        end else begin
            bus.oMulStart <= accept;
            if (accept) begin
                rr_ptr        <= next_ptr;
                issue_id      <= gnt_idx;
                bus.oMulMant1 <= sel_mant1;
                bus.oMulExp1  <= sel_exp1;
                bus.oMulMant2 <= sel_mant2;
                bus.oMulExp2  <= sel_exp2;
            end

            tag_v[0]  <= bus.oMulStart;
            tag_id[0] <= issue_id;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end

            bus.oRspValid <= tag_v[MUL_LAT-1];
            if (tag_v[MUL_LAT-1]) begin
                bus.oRspId   <= tag_id[MUL_LAT-1];
                bus.oRspMant <= bus.iMulMantR;
                bus.oRspExp  <= bus.iMulExpR;
            end

            // Busy clears on the edge the response registers, so a new op can
            // be accepted in the same cycle oRspValid is high.
            if (accept) begin
                busy <= 1'b1;
            end else if (tag_v[MUL_LAT-1]) begin
                busy <= 1'b0;
            end
        end
    end

`ifdef FFT_MULT_OPCNT_EN
    always_ff @(posedge clkExt or negedge rstN) begin
        if (!rstN) begin
            oOpCount <= '0;
        end else if (accept) begin
            oOpCount <= oOpCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_mult_scheduler.sv
// tb/tb_fft_mult_scheduler.sv - directed bench for fft_mult_scheduler, pipelined and non-pipelined builds
module tb_fft_mult_scheduler;
    import fft_float_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0]  req_valid = '0;
    logic [39:0] m1 = '0;
    logic [39:0] m2 = '0;
    logic [19:0] e1 = '0;
    logic [19:0] e2 = '0;
    logic        saw_rsp;

    fft_mult_scheduler_if #(.NREQ(4)) bus_p ();
    fft_mult_scheduler_if #(.NREQ(4)) bus_s ();

    assign bus_p.iReqValid = req_valid;
    assign bus_p.iReqMant1 = m1;
    assign bus_p.iReqExp1  = e1;
    assign bus_p.iReqMant2 = m2;
    assign bus_p.iReqExp2  = e2;
    assign bus_s.iReqValid = req_valid;
    assign bus_s.iReqMant1 = m1;
    assign bus_s.iReqExp1  = e1;
    assign bus_s.iReqMant2 = m2;
    assign bus_s.iReqExp2  = e2;

    // Stub multipliers: two-stage fixed latency, result {mant1,5'b0}^{5'b0,mant2}, exp1+exp2.
    logic [14:0] p_m0, p_m1, s_m0, s_m1;
    logic [4:0]  p_e0, p_e1, s_e0, s_e1;
    always @(posedge clk) begin
        p_m0 <= {bus_p.oMulMant1, 5'b0} ^ {5'b0, bus_p.oMulMant2};
        p_e0 <= bus_p.oMulExp1 + bus_p.oMulExp2;
        p_m1 <= p_m0;
        p_e1 <= p_e0;
        s_m0 <= {bus_s.oMulMant1, 5'b0} ^ {5'b0, bus_s.oMulMant2};
        s_e0 <= bus_s.oMulExp1 + bus_s.oMulExp2;
        s_m1 <= s_m0;
        s_e1 <= s_e0;
    end
    assign bus_p.iMulMantR = p_m1;
    assign bus_p.iMulExpR  = p_e1;
    assign bus_s.iMulMantR = s_m1;
    assign bus_s.iMulExpR  = s_e1;

`ifdef FFT_MULT_OPCNT_EN
    logic [15:0] opcnt_p, opcnt_s;
`endif

    fft_mult_scheduler #(.NREQ(4), .MUL_LAT(2), .MUL_PIPE(1)) dut_p (
        .clkExt   (clk),
        .rstN     (rst_n),
        .bus      (bus_p)
`ifdef FFT_MULT_OPCNT_EN
        ,
        .oOpCount (opcnt_p)
`endif
    );

    fft_mult_scheduler #(.NREQ(4), .MUL_LAT(2), .MUL_PIPE(0)) dut_s (
        .clkExt   (clk),
        .rstN     (rst_n),
        .bus      (bus_s)
`ifdef FFT_MULT_OPCNT_EN
        ,
        .oOpCount (opcnt_s)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        check("rst_ready",    32'(bus_s.oReqReady), 32'h0);
        check("rst_mulstart", 32'(bus_s.oMulStart), 32'h0);
        check("rst_mulmant1", 32'(bus_s.oMulMant1), 32'h0);
        check("rst_rspvalid", 32'(bus_s.oRspValid), 32'h0);
        check("rst_rspmant",  32'(bus_s.oRspMant),  32'h0);
        check("rst_rspid",    32'(bus_p.oRspId),    32'h0);

        // Single op from requester 0: issue at t+1, response at t+4
        m1 = 40'h1DC; e1 = 20'h1D; m2 = 40'h110; e2 = 20'h03;
        req_valid = 4'b0001;
        #1;
        check("t1_ready", 32'(bus_s.oReqReady), 32'h1);
        tick();
        req_valid = 4'b0000;
        #1;
        check("t1_start",  32'(bus_s.oMulStart), 32'h1);
        check("t1_opm1",   32'(bus_s.oMulMant1), 32'h1DC);
        check("t1_ope1",   32'(bus_s.oMulExp1),  32'h1D);
        check("t1_opm2",   32'(bus_s.oMulMant2), 32'h110);
        check("t1_busy_ready", 32'(bus_s.oReqReady), 32'h0);
        tick();
        #1;
        check("t1_start_pulse", 32'(bus_s.oMulStart), 32'h0);
        tick();
        #1;
        check("t1_rsp_early", 32'(bus_s.oRspValid), 32'h0);
        tick();
        #1;
        check("t1_rspvalid", 32'(bus_s.oRspValid), 32'h1);
        check("t1_rspid",    32'(bus_s.oRspId),    32'h0);
        check("t1_rspmant",  32'(bus_s.oRspMant),  32'h3A90);
        check("t1_rspexp",   32'(bus_s.oRspExp),   32'h00);
        check("t1_p_rspmant", 32'(bus_p.oRspMant), 32'h3A90);
        tick();
        #1;
        check("t1_rsp_pulse", 32'(bus_s.oRspValid), 32'h0);
        check("t1_rsp_held",  32'(bus_s.oRspMant),  32'h3A90);

        // All four requesting continuously
        do_reset();
        m1 = {10'h004, 10'h003, 10'h002, 10'h001};
        e1 = {5'd3, 5'd2, 5'd1, 5'd0};
        m2 = '0;
        e2 = '0;
        req_valid = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            #1;
            check($sformatf("all_p_ready_%0d", k), 32'(bus_p.oReqReady), 32'(4'b0001 << (k % 4)));
            check($sformatf("all_s_ready_%0d", k), 32'(bus_s.oReqReady),
                  (k % 4 == 0) ? 32'(4'b0001 << (k / 4)) : 32'h0);
            check($sformatf("all_p_rspvalid_%0d", k), 32'(bus_p.oRspValid), (k >= 4) ? 32'h1 : 32'h0);
            if (k >= 4) begin
                check($sformatf("all_p_rspid_%0d", k),   32'(bus_p.oRspId),   32'((k - 4) % 4));
                check($sformatf("all_p_rspmant_%0d", k), 32'(bus_p.oRspMant), 32'(((k - 4) % 4 + 1) << 5));
                check($sformatf("all_p_rspexp_%0d", k),  32'(bus_p.oRspExp),  32'((k - 4) % 4));
            end
            check($sformatf("all_s_rspvalid_%0d", k), 32'(bus_s.oRspValid),
                  (k == 4 || k == 8) ? 32'h1 : 32'h0);
            if (k == 4 || k == 8) begin
                check($sformatf("all_s_rspid_%0d", k),   32'(bus_s.oRspId),   32'(k / 4 - 1));
                check($sformatf("all_s_rspmant_%0d", k), 32'(bus_s.oRspMant), 32'((k / 4) << 5));
            end
            tick();
        end
        req_valid = 4'b0000;

        // Wrap: pointer at 2 after granting req1; req1+req3 -> 3 then 1
        do_reset();
        req_valid = 4'b0010;
        #1;
        check("wrap_first", 32'(bus_p.oReqReady), 32'h2);
        tick();
        req_valid = 4'b1010;
        #1;
        check("wrap_req3", 32'(bus_p.oReqReady), 32'h8);
        tick();
        #1;
        check("wrap_req1", 32'(bus_p.oReqReady), 32'h2);
        tick();
        req_valid = 4'b0000;

        // Reset one cycle after accept: op discarded, pointer back to 0
        do_reset();
        req_valid = 4'b0001;
        #1;
        check("rstmid_ready", 32'(bus_p.oReqReady), 32'h1);
        tick();
        req_valid = 4'b0000;
        rst_n = 1'b0;
        #1;
        check("rstmid_start_clr", 32'(bus_p.oMulStart), 32'h0);
        tick();
        rst_n = 1'b1;
        saw_rsp = 1'b0;
        for (int k = 0; k < 8; k++) begin
            saw_rsp = saw_rsp | bus_p.oRspValid | bus_s.oRspValid;
            tick();
        end
        check("rstmid_no_rsp", 32'(saw_rsp), 32'h0);
        req_valid = 4'b0011;
        #1;
        check("rstmid_ptr_p", 32'(bus_p.oReqReady), 32'h1);
        check("rstmid_ptr_s", 32'(bus_s.oReqReady), 32'h1);
        tick();
        req_valid = 4'b0000;

`ifdef FFT_MULT_OPCNT_EN
        do_reset();
        #1;
        check("opcnt_rst", 32'(opcnt_p), 32'h0);
        req_valid = 4'b1111;
        repeat (70000) tick();
        req_valid = 4'b0000;
        #1;
        check("opcnt_p_wrap", 32'(opcnt_p), 32'd4464);
        check("opcnt_s",      32'(opcnt_s), 32'd17500);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
